// File: rtl/nibble_divider_ctrl_if.sv
// Start/operand/result bundle for the nibble divider controller.
interface nibble_divider_ctrl_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic [WIDTH-1:0] X;
   logic [WIDTH-1:0] Y;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             busy;
   logic             done;
   logic             div_by_zero;

   modport master (
      output start, X, Y,
      input  quotient, remainder, busy, done, div_by_zero
   );

   modport slave (
      input  start, X, Y,
      output quotient, remainder, busy, done, div_by_zero
   );
endinterface

// File: rtl/nibble_divider_ctrl.sv
// Sequential restoring divider: one trial subtraction per clock, busy/done handshake,
// divide-by-zero short-circuits straight to the result cycle.
module nibble_divider_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   nibble_divider_ctrl_if.slave  bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] q_reg, d_reg;
   logic [WIDTH:0]   r_reg;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] quot, rem;
   logic             dbz;

   logic [WIDTH:0]   t, r_step;
   logic [WIDTH+1:0] sub;
   logic [WIDTH-1:0] q_step;
   logic             borrow, accept, y_zero, last;
   logic             r_msb_unused;

   assign y_zero = (bus.Y == '0);
   assign accept = bus.start && (state != CALC);
   assign last   = (cnt == CW'(WIDTH - 1));

   // Trial subtraction of D from the shifted partial remainder
   always_comb begin
      t      = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
      sub    = {1'b0, t} - {2'b00, d_reg};
      borrow = sub[WIDTH+1];
      r_step = borrow ? t : sub[WIDTH:0];
      q_step = {q_reg[WIDTH-2:0], ~borrow};
   end

   // R stays below D after every restore, so its top bit never feeds back
   assign r_msb_unused = r_reg[WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: begin
            if (bus.start) state_nxt = y_zero ? DONE : CALC;
            else           state_nxt = IDLE;
         end
         CALC:    if (last) state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.busy = (state == CALC);
      bus.done = (state == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_reg <= '0;
         d_reg <= '0;
         r_reg <= '0;
         cnt   <= '0;
      end else if (accept && !y_zero) begin
         q_reg <= bus.X;
         d_reg <= bus.Y;
         r_reg <= '0;
         cnt   <= '0;
      end else if (state == CALC) begin
         q_reg <= q_step;
         r_reg <= r_step;
         cnt   <= cnt + 1'b1;
      end
   end

   // Results move only on a completion edge, so they hold through the next busy period
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         quot <= '0;
         rem  <= '0;
         dbz  <= 1'b0;
      end else if (accept && y_zero) begin
         quot <= '1;
         rem  <= bus.X;
         dbz  <= 1'b1;
      end else if (state == CALC && last) begin
         quot <= q_step;
         rem  <= r_step[WIDTH-1:0];
         dbz  <= 1'b0;
      end
   end

   assign bus.quotient    = quot;
   assign bus.remainder   = rem;
   assign bus.div_by_zero = dbz;
endmodule

// File: tb/tb_nibble_divider_ctrl.sv
// Scoreboard bench: stimulus pushes expected results, a negedge monitor pops on done.
module tb_nibble_divider_ctrl;
   localparam int W = 4;

   typedef struct {
      int q;
      int r;
      int z;
   } res_t;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   res_t sb[$];
   res_t mon_e;
   int   pq, pr;

   nibble_divider_ctrl_if #(.WIDTH(W)) bus ();

   nibble_divider_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Caller is at a negedge; start is sampled on the following posedge
   task automatic issue(input int x, input int y, input int q, input int r, input int z,
                        input bit push);
      res_t e;
      bus.start = 1'b1;
      bus.X     = x[W-1:0];
      bus.Y     = y[W-1:0];
      if (push) begin
         e.q = q; e.r = r; e.z = z;
         sb.push_back(e);
      end
      @(posedge clk);
      #1 bus.start = 1'b0;
   endtask

   task automatic wait_done(input int lat, input int hq, input int hr);
      int n = 0;
      int b = 0;
      do begin
         @(negedge clk);
         n++;
         if (bus.busy) begin
            b++;
            chk("hold_quotient", int'(bus.quotient), hq);
            chk("hold_remainder", int'(bus.remainder), hr);
         end
      end while (!bus.done && n < 20);
      chk("done_latency", n, lat + 1);
      chk("busy_cycles", b, lat);
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            chk("quotient", int'(bus.quotient), mon_e.q);
            chk("remainder", int'(bus.remainder), mon_e.r);
            chk("div_by_zero", int'(bus.div_by_zero), mon_e.z);
         end
      end
   end

   initial begin
      clk = 1'b0;
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.X = '0;
      bus.Y = '0;
      #12;
      chk("rst_quotient", int'(bus.quotient), 0);
      chk("rst_remainder", int'(bus.remainder), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_dbz", int'(bus.div_by_zero), 0);
      @(negedge clk) rst_n = 1'b1;

      @(negedge clk); issue(13, 3, 4, 1, 0, 1);   wait_done(W, 0, 0);
      @(negedge clk); issue(15, 1, 15, 0, 0, 1);  wait_done(W, 4, 1);
      @(negedge clk); issue(7, 9, 0, 7, 0, 1);    wait_done(W, 15, 0);
      @(negedge clk); issue(0, 5, 0, 0, 0, 1);    wait_done(W, 0, 7);
      @(negedge clk); issue(15, 15, 1, 0, 0, 1);  wait_done(W, 0, 0);

      // Divide by zero, then a normal run clears the flag
      @(negedge clk); issue(6, 0, 15, 6, 1, 1);   wait_done(0, 0, 0);
      @(negedge clk); issue(8, 2, 4, 0, 0, 1);    wait_done(W, 15, 6);

      // Start while busy must be ignored
      @(negedge clk); issue(14, 4, 3, 2, 0, 1);
      fork
         begin
            repeat (2) @(negedge clk);
            bus.start = 1'b1; bus.X = 4'd9; bus.Y = 4'd3;
            @(posedge clk);
            #1 bus.start = 1'b0;
         end
      join_none
      wait_done(W, 4, 0);

      // Back-to-back: new request taken in the done cycle
      @(negedge clk); issue(11, 2, 5, 1, 0, 1);   wait_done(W, 3, 2);
      issue(12, 5, 2, 2, 0, 1);                   wait_done(W, 5, 1);

      // Asynchronous reset in the middle of a calculation
      @(negedge clk); issue(13, 3, 0, 0, 0, 0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_quotient", int'(bus.quotient), 0);
      chk("arst_remainder", int'(bus.remainder), 0);
      chk("arst_busy", int'(bus.busy), 0);
      chk("arst_done", int'(bus.done), 0);
      chk("arst_dbz", int'(bus.div_by_zero), 0);
      @(negedge clk) rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("idle_after_reset", int'(bus.busy), 0);
      issue(13, 3, 4, 1, 0, 1);                   wait_done(W, 0, 0);

      pq = 4; pr = 1;
      for (int x = 0; x < 16; x++) begin
         for (int y = 1; y < 16; y++) begin
            @(negedge clk); issue(x, y, x / y, x % y, 0, 1);
            wait_done(W, pq, pr);
            pq = x / y;
            pr = x % y;
         end
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
